alu_seq: RTL and testbench

- Parametrised, registered successor to the datapath ALU of the 8-bit CPU core.
- Adds a multi-op opcode set, a persistent flag register (Z/C/N/V) with carry-in chaining, and an iterative shift-add multiplier.
- Uses a start/busy/done handshake.
- Sits between the A/B registers and the bus driver; the flag register feeds the controller's conditional-jump logic.

---
 rtl/alu_pkg.sv | 43 ++++
 rtl/alu_seq_if.sv | 31 +++
 rtl/alu_mul_iter.sv | 49 ++++
 rtl/alu_seq.sv | 158 +++++++++++++++
 tb/tb_alu_seq.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcode set, flag bit positions and FSM states.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_ADC   = 4'd2,
    OP_SBC   = 4'd3,
    OP_AND   = 4'd4,
    OP_OR    = 4'd5,
    OP_XOR   = 4'd6,
    OP_NOT   = 4'd7,
    OP_SHL   = 4'd8,
    OP_SHR   = 4'd9,
    OP_ASR   = 4'd10,
    OP_CMP   = 4'd11,
    OP_MUL   = 4'd12,
    OP_RSV13 = 4'd13,
    OP_RSV14 = 4'd14,
    OP_RSV15 = 4'd15
  } alu_op_t;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } fsm_state_t;

  // Opcodes ADD..ASR are the single-cycle ops that overwrite result.
  function automatic logic writes_result(alu_op_t op);
    return (op <= OP_ASR);
  endfunction

  // CMP additionally updates flags without touching result; MUL writes flags from its own path.
  function automatic logic writes_flags(alu_op_t op);
    return (op <= OP_CMP);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Issue/response bundle between the CPU controller and the sequential ALU.
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  import alu_pkg::*;

  logic             start;
  alu_op_t          op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flags_clr;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             done;
  logic             busy;
  logic             flag_z;
  logic             flag_c;
  logic             flag_n;
  logic             flag_v;

  modport master (
    output start, op, a, b, flags_clr,
    input  result, result_hi, done, busy, flag_z, flag_c, flag_n, flag_v
  );

  modport slave (
    input  start, op, a, b, flags_clr,
    output result, result_hi, done, busy, flag_z, flag_c, flag_n, flag_v
  );

endinterface

// File: rtl/alu_mul_iter.sv
// Iterative shift-add unsigned multiplier: one partial-product add per step, WIDTH steps per product.
module alu_mul_iter #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product,
  output logic               last
);

  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [2*WIDTH-1:0] prod_next;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     upper;

  // Low half starts as the multiplier and is consumed LSB-first as the sum shifts in from the top.
  always_comb begin
    addend    = prod_q[0] ? mcand_q : '0;
    upper     = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    prod_next = {upper, prod_q[WIDTH-1:1]};
  end

  // product reflects the step in progress, so the final step's value is ready at its own edge.
  assign product = prod_next;
  assign last    = (cnt_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
    end else if (load) begin
      mcand_q <= a;
      prod_q  <= {{WIDTH{1'b0}}, b};
      cnt_q   <= '0;
    end else if (step) begin
      prod_q  <= prod_next;
      cnt_q   <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered multi-op ALU with persistent Z/C/N/V flags and an iterative multiplier behind a start/busy/done handshake.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_seq_if.slave bus
);

  fsm_state_t         state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   result_hi_q, result_hi_d;
  logic [3:0]         flags_q, flags_d;
  logic               done_q, done_d;

  logic               mul_load, mul_step, mul_last;
  logic [2*WIDTH-1:0] mul_product;

  logic [WIDTH-1:0]   b_eff;
  logic [WIDTH:0]     sum;
  logic               cin;
  logic [WIDTH-1:0]   op_val;
  logic               op_c, op_v;
  logic [3:0]         op_flags, mul_flags;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (mul_load),
    .step    (mul_step),
    .a       (bus.a),
    .b       (bus.b),
    .product (mul_product),
    .last    (mul_last)
  );

  // One shared adder serves all four arithmetic ops and CMP; subtraction feeds it ~b.
  always_comb begin
    b_eff = (bus.op inside {OP_SUB, OP_SBC, OP_CMP}) ? ~bus.b : bus.b;
    case (bus.op)
      OP_SUB, OP_CMP: cin = 1'b1;
      OP_ADC, OP_SBC: cin = flags_q[FLAG_C];
      default:        cin = 1'b0;
    endcase
    sum = {1'b0, bus.a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
  end

  always_comb begin
    op_val = sum[WIDTH-1:0];
    op_c   = sum[WIDTH];
    op_v   = (bus.a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
    case (bus.op)
      OP_AND: begin op_val = bus.a & bus.b; op_c = 1'b0; op_v = 1'b0; end
      OP_OR:  begin op_val = bus.a | bus.b; op_c = 1'b0; op_v = 1'b0; end
      OP_XOR: begin op_val = bus.a ^ bus.b; op_c = 1'b0; op_v = 1'b0; end
      OP_NOT: begin op_val = ~bus.a;        op_c = 1'b0; op_v = 1'b0; end
      OP_SHL: begin
        op_val = {bus.a[WIDTH-2:0], 1'b0};
        op_c   = bus.a[WIDTH-1];
        op_v   = 1'b0;
      end
      OP_SHR: begin
        op_val = {1'b0, bus.a[WIDTH-1:1]};
        op_c   = bus.a[0];
        op_v   = 1'b0;
      end
      OP_ASR: begin
        op_val = {bus.a[WIDTH-1], bus.a[WIDTH-1:1]};
        op_c   = bus.a[0];
        op_v   = 1'b0;
      end
      default: ;
    endcase
  end

  always_comb begin
    op_flags         = '0;
    op_flags[FLAG_Z] = ~|op_val;
    op_flags[FLAG_C] = op_c;
    op_flags[FLAG_N] = op_val[WIDTH-1];
    op_flags[FLAG_V] = op_v;

    mul_flags         = '0;
    mul_flags[FLAG_Z] = ~|mul_product;
    mul_flags[FLAG_C] = |mul_product[2*WIDTH-1:WIDTH];
    mul_flags[FLAG_N] = mul_product[2*WIDTH-1];
    mul_flags[FLAG_V] = 1'b0;
  end

  // A flag write from a completing op overrides a coincident flags_clr.
  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    flags_d     = bus.flags_clr ? 4'b0000 : flags_q;
    done_d      = 1'b0;
    mul_load    = 1'b0;
    mul_step    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.op == OP_MUL) begin
            mul_load = 1'b1;
            state_d  = MUL;
          end else begin
            done_d = 1'b1;
            if (writes_result(bus.op)) begin
              result_d    = op_val;
              result_hi_d = '0;
            end
            if (writes_flags(bus.op)) begin
              flags_d = op_flags;
            end
          end
        end
      end
      MUL: begin
        mul_step = 1'b1;
        if (mul_last) begin
          result_d    = mul_product[WIDTH-1:0];
          result_hi_d = mul_product[2*WIDTH-1:WIDTH];
          flags_d     = mul_flags;
          done_d      = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      result_q    <= '0;
      result_hi_q <= '0;
      flags_q     <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      flags_q     <= flags_d;
      done_q      <= done_d;
    end
  end

  assign bus.result    = result_q;
  assign bus.result_hi = result_hi_q;
  assign bus.done      = done_q;
  assign bus.busy      = (state_q == MUL);
  assign bus.flag_z    = flags_q[FLAG_Z];
  assign bus.flag_c    = flags_q[FLAG_C];
  assign bus.flag_n    = flags_q[FLAG_N];
  assign bus.flag_v    = flags_q[FLAG_V];

endmodule

// File: tb/tb_alu_seq.sv
// Directed scoreboard bench for alu_seq: an integer-arithmetic model queues expected results at issue time.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int WIDTH = 8;

  typedef struct packed {
    logic [7:0] res;
    logic [7:0] hi;
    logic [3:0] flg;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   tests_run = 0;
  int   tests_failed = 0;
  exp_t sb[$];
  logic [7:0] m_res, m_hi;
  logic [3:0] m_flg;

  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(WIDTH)) bus ();

  alu_seq #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests_run++;
    assert (obs === expv) else begin
      tests_failed++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      $error("[TB] check %s", tag);
    end
  endtask

  function automatic logic [3:0] dut_flags();
    return {bus.flag_v, bus.flag_n, bus.flag_c, bus.flag_z};
  endfunction

  // Reference behaviour in plain integer arithmetic; flags held as {V,N,C,Z}.
  function automatic void model_op(input logic [3:0] opc, input logic [7:0] a, input logic [7:0] b,
                                   input logic clr);
    int ua = a, ub = b, sa = $signed(a), sbv = $signed(b);
    int full = 0, sfull = 0, brw, cin, p;
    logic [7:0] r = m_res;
    logic c = 1'b0, v, z, n;
    bit wres = 0, wfl = 0;
    case (opc)
      4'd0:  begin full = ua + ub; sfull = sa + sbv; r = full[7:0]; c = full > 255; wres = 1; wfl = 1; end
      4'd1,
      4'd11: begin r = 8'(ua - ub); c = ua >= ub; sfull = sa - sbv; wres = (opc == 4'd1); wfl = 1; end
      4'd2:  begin
        cin = m_flg[1] ? 1 : 0;
        full = ua + ub + cin; sfull = sa + sbv + cin; r = full[7:0]; c = full > 255; wres = 1; wfl = 1;
      end
      4'd3:  begin
        brw = m_flg[1] ? 0 : 1;
        r = 8'(ua - ub - brw); c = ua >= ub + brw; sfull = sa - sbv - brw; wres = 1; wfl = 1;
      end
      4'd4:  begin r = a & b; wres = 1; wfl = 1; end
      4'd5:  begin r = a | b; wres = 1; wfl = 1; end
      4'd6:  begin r = a ^ b; wres = 1; wfl = 1; end
      4'd7:  begin r = ~a;    wres = 1; wfl = 1; end
      4'd8:  begin r = {a[6:0], 1'b0}; c = a[7]; wres = 1; wfl = 1; end
      4'd9:  begin r = {1'b0, a[7:1]}; c = a[0]; wres = 1; wfl = 1; end
      4'd10: begin r = {a[7], a[7:1]}; c = a[0]; wres = 1; wfl = 1; end
      default: ;
    endcase
    v = (sfull > 127) || (sfull < -128);
    z = (r == 8'h00);
    n = r[7];
    if (opc == 4'd12) begin
      p     = ua * ub;
      m_res = p[7:0];
      m_hi  = p[15:8];
      m_flg = {1'b0, p[15], p[15:8] != 8'h00, p == 0};
    end else begin
      if (wfl)      m_flg = {v, n, c, z};
      else if (clr) m_flg = 4'b0000;
      if (wres) begin
        m_res = r;
        m_hi  = 8'h00;
      end
    end
    sb.push_back({m_res, m_hi, m_flg});
  endfunction

  task automatic applyStimulus(input logic [3:0] opc, input logic [7:0] a, input logic [7:0] b,
                               input logic clr);
    @(negedge clk);
    bus.op        = alu_op_t'(opc);
    bus.a         = a;
    bus.b         = b;
    bus.flags_clr = clr;
    bus.start     = 1'b1;
    model_op(opc, a, b, clr);
    @(negedge clk);
    bus.start     = 1'b0;
    bus.flags_clr = 1'b0;
  endtask

  // Waits (bounded) for done, checking latency and busy span, then compares against the scoreboard head.
  task automatic checkOutput(input string tag, input int exp_lat);
    int   n = 0, busy_n = 0;
    exp_t e;
    while (bus.done !== 1'b1 && n < 40) begin
      if (bus.busy === 1'b1) busy_n++;
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, n, exp_lat);
    check({tag, " busy_cycles"}, busy_n, exp_lat);
    check({tag, " busy_at_done"}, bus.busy, 1'b0);
    check({tag, " sb_nonempty"}, sb.size() > 0, 1'b1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, " result"}, bus.result, e.res);
      check({tag, " result_hi"}, bus.result_hi, e.hi);
      check({tag, " flags_vncz"}, dut_flags(), e.flg);
    end
    @(negedge clk);
    check({tag, " done_one_cycle"}, bus.done, 1'b0);
  endtask

  initial begin
    logic [3:0] lops [6];
    lops = '{4'd4, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10};

    bus.start = 1'b0; bus.op = OP_ADD; bus.a = '0; bus.b = '0; bus.flags_clr = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #11;
    check("reset result", bus.result, 8'h00);
    check("reset result_hi", bus.result_hi, 8'h00);
    check("reset done", bus.done, 1'b0);
    check("reset busy", bus.busy, 1'b0);
    check("reset flags", dut_flags(), 4'h0);
    m_res = 8'h00; m_hi = 8'h00; m_flg = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(4'd0, 8'h7F, 8'h01, 1'b0);
    checkOutput("add_7f_01", 0);
    check("add_7f_01 const_result", bus.result, 8'h80);
    check("add_7f_01 const_flags", dut_flags(), 4'b1100);

    applyStimulus(4'd1, 8'h05, 8'h05, 1'b0);
    checkOutput("sub_05_05", 0);
    check("sub_05_05 const_flags", dut_flags(), 4'b0011);
    applyStimulus(4'd1, 8'h00, 8'h01, 1'b0);
    checkOutput("sub_00_01", 0);
    check("sub_00_01 const_flags", dut_flags(), 4'b0100);

    applyStimulus(4'd0, 8'hFF, 8'h01, 1'b0);
    checkOutput("add_ff_01", 0);
    applyStimulus(4'd2, 8'h00, 8'h00, 1'b0);
    checkOutput("adc_carry_in", 0);
    check("adc_carry_in const_result", bus.result, 8'h01);
    applyStimulus(4'd3, 8'h05, 8'h01, 1'b0);
    checkOutput("sbc_borrow_in", 0);
    check("sbc_borrow_in const_result", bus.result, 8'h03);

    foreach (lops[i]) begin
      applyStimulus(lops[i], 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0);
      checkOutput($sformatf("logic_op%0d", lops[i]), 0);
    end

    // MUL with an ADD issued mid-iteration, which must be dropped.
    applyStimulus(4'd12, 8'hFF, 8'hFF, 1'b0);
    @(negedge clk);
    @(negedge clk);
    bus.op = OP_ADD; bus.a = 8'h01; bus.b = 8'h01; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    checkOutput("mul_ff_ff", 5);
    check("mul_ff_ff const_hi", bus.result_hi, 8'hFE);
    check("mul_ff_ff const_lo", bus.result, 8'h01);
    check("mul_ff_ff const_c", bus.flag_c, 1'b1);
    check("mul_ff_ff extra_done", sb.size(), 0);

    applyStimulus(4'd12, 8'h00, 8'h37, 1'b0);
    checkOutput("mul_00_37", 8);
    check("mul_00_37 const_z", bus.flag_z, 1'b1);
    applyStimulus(4'd12, 8'hA5, 8'h3C, 1'b0);
    checkOutput("mul_a5_3c", 8);

    // Asynchronous reset partway through a multiply.
    applyStimulus(4'd12, 8'hFF, 8'hFF, 1'b0);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset result", bus.result, 8'h00);
    check("midreset result_hi", bus.result_hi, 8'h00);
    check("midreset busy", bus.busy, 1'b0);
    check("midreset done", bus.done, 1'b0);
    check("midreset flags", dut_flags(), 4'h0);
    sb.delete();
    m_res = 8'h00; m_hi = 8'h00; m_flg = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(4'd0, 8'h02, 8'h03, 1'b0);
    checkOutput("add_after_reset", 0);
    check("add_after_reset const", bus.result, 8'h05);

    applyStimulus(4'd11, 8'h10, 8'h20, 1'b0);
    checkOutput("cmp_10_20", 0);
    check("cmp_10_20 const_result", bus.result, 8'h05);
    applyStimulus(4'd15, 8'hAA, 8'h55, 1'b0);
    checkOutput("reserved_f", 0);
    applyStimulus(4'd8, 8'h81, 8'h00, 1'b1);
    checkOutput("shl_with_clr", 0);
    check("shl_with_clr const_c", bus.flag_c, 1'b1);

    @(negedge clk);
    bus.flags_clr = 1'b1;
    @(negedge clk);
    bus.flags_clr = 1'b0;
    m_flg = 4'h0;
    check("flags_clr flags", dut_flags(), m_flg);
    check("flags_clr result", bus.result, m_res);
    check("flags_clr done", bus.done, 1'b0);
    check("flags_clr busy", bus.busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
